fetch_queue: RTL

Parametrised instruction-fetch unit with a prefetch queue, the next generation of the fixed 8-bit program counter in the `main_2` single-cycle core. It generates the PC, issues requests to a 1-cycle-latency synchronous instruction memory, and buffers returned instructions with their PCs in a DEPTH-entry FIFO. Downstream decode drains the FIFO through a valid/ready handshake. A redirect input (branch/jump) flushes the queue and any in-flight fetch.

---
 rtl/fetch_queue.sv | 135 +++++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch unit with a DEPTH-entry prefetch FIFO.
// It generates the fetch PC and issues requests to a synchronous memory
// whose data returns one cycle after the request. Each returned
// instruction is buffered together with its PC, and decode drains the
// FIFO through a valid/ready handshake. A redirect empties the queue,
// drops any fetch still in flight and restarts fetching at redirect_pc_i.
//
// Ports
//   clk_i          rising-edge clock
//   rst_ni         asynchronous active-low reset
//   imem_req_o     fetch request this cycle (combinational)
//   imem_addr_o    fetch address (equals fetch_pc_o)
//   imem_data_i    memory data, valid the cycle after imem_req_o
//   redirect_i     flush the queue and restart at redirect_pc_i
//   redirect_pc_i  new fetch address
//   out_valid_o    head entry valid
//   out_ready_i    consumer accepts the head entry
//   out_instr_o    head instruction (0 when out_valid_o=0)
//   out_pc_o       head PC (0 when out_valid_o=0)
//   fetch_pc_o     next PC to request
//   count_o        number of occupied entries
module fetch_queue #(
  parameter int unsigned           PC_W     = 8,
  parameter int unsigned           INSTR_W  = 16,
  parameter int unsigned           DEPTH    = 4,
  parameter logic [PC_W-1:0]       RESET_PC = '0,
  parameter logic [PC_W-1:0]       PC_STEP  = PC_W'(1)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  output logic                         imem_req_o,
  output logic [PC_W-1:0]              imem_addr_o,
  input  logic [INSTR_W-1:0]           imem_data_i,
  input  logic                         redirect_i,
  input  logic [PC_W-1:0]              redirect_pc_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [INSTR_W-1:0]           out_instr_o,
  output logic [PC_W-1:0]              out_pc_o,
  output logic [PC_W-1:0]              fetch_pc_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PC_W-1:0]    fetch_pc_q, fetch_pc_d;
  logic               inflight_q, inflight_d;
  logic [PC_W-1:0]    inflight_pc_q, inflight_pc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;

  logic [INSTR_W-1:0] instr_mem_q [DEPTH];
  logic [PC_W-1:0]    pc_mem_q    [DEPTH];

  logic               pop;
  logic               push;
  logic               credit_ok;
  logic [CNT_W:0]     occupancy;

  assign out_valid_o = (count_q != '0);
  assign out_instr_o = out_valid_o ? instr_mem_q[rd_ptr_q] : '0;
  assign out_pc_o    = out_valid_o ? pc_mem_q[rd_ptr_q]    : '0;
  assign fetch_pc_o  = fetch_pc_q;
  assign imem_addr_o = fetch_pc_q;
  assign count_o     = count_q;

  assign pop  = out_valid_o & out_ready_i;
  // A response arriving during a redirect belongs to the old stream.
  assign push = inflight_q & ~redirect_i;

  // Entries held plus the one in flight, less the one leaving this cycle.
  // Counting the pop lets a DEPTH=2 queue sustain one fetch per cycle.
  assign occupancy  = {1'b0, count_q} + (CNT_W+1)'(inflight_q) - (CNT_W+1)'(pop);
  assign credit_ok  = (occupancy < (CNT_W+1)'(DEPTH));
  // Gating with rst_ni keeps the request low the instant reset asserts.
  assign imem_req_o = rst_ni & ~redirect_i & credit_ok;

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    inflight_d    = 1'b0;
    inflight_pc_d = inflight_pc_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;

    if (redirect_i) begin
      fetch_pc_d = redirect_pc_i;
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (imem_req_o) begin
        fetch_pc_d    = fetch_pc_q + PC_STEP;
        inflight_d    = 1'b1;
        inflight_pc_d = fetch_pc_q;
      end
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
    end
  end

  // Storage needs no reset: contents are masked until count_q covers them.
  always_ff @(posedge clk_i) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= imem_data_i;
      pc_mem_q[wr_ptr_q]    <= inflight_pc_q;
    end
  end

endmodule
